// File: rtl/ps2_pkg.sv
// Shared PS/2 scancode constants and the event record carried from prefix decoders to the FIFO.
// Used by ps2_keyboard consumers as well as ps2_scan_fifo.
package ps2_pkg;

  localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

  // Wide enough for the 4-channel maximum; narrower builds use the low bits.
  localparam int PS2_CHAN_W = 2;

  typedef struct packed {
    logic [PS2_CHAN_W-1:0] chan;
    logic                  ext;
    logic                  brk;
    logic [7:0]            code;
  } ps2_evt_t;

  function automatic logic ps2_is_prefix(input logic [7:0] b);
    return (b == PS2_PFX_EXT) || (b == PS2_PFX_BRK);
  endfunction

endpackage

// File: rtl/ps2_prefix_dec.sv
// Per-channel E0/F0 prefix folding plus a one-entry pending register; event valid 1 edge after the byte.
// Holds its entry until granted; a further event while holding is dropped and flagged on drop.
module ps2_prefix_dec
  import ps2_pkg::*;
#(
  parameter int CHAN = 0
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic [7:0] rx_data,
  input  logic       rx_en,
  input  logic       grant,
  output logic       pend_valid,
  output ps2_evt_t   pend_event,
  output logic       drop
);

  localparam logic [PS2_CHAN_W-1:0] CHAN_TAG = PS2_CHAN_W'(CHAN);

  logic ext;
  logic brk;
  logic fire;

  assign fire = rx_en && !ps2_is_prefix(rx_data);
  // The held entry wins even if it is being granted this cycle.
  assign drop = fire && pend_valid;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      ext        <= 1'b0;
      brk        <= 1'b0;
      pend_valid <= 1'b0;
      pend_event <= '0;
    end else begin
      if (rx_en) begin
        if (rx_data == PS2_PFX_EXT) begin
          ext <= 1'b1;
        end else if (rx_data == PS2_PFX_BRK) begin
          brk <= 1'b1;
        end else begin
          ext <= 1'b0;
          brk <= 1'b0;
        end
      end
      if (fire && !pend_valid) begin
        pend_valid <= 1'b1;
        pend_event <= '{chan: CHAN_TAG, ext: ext, brk: brk, code: rx_data};
      end else if (grant) begin
        pend_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ps2_scan_fifo.sv
// Multi-channel PS/2 scancode collector: fixed-priority arbiter into a show-ahead FIFO, 2-cycle min latency.
// Pending entries wait while full unless rd frees a slot; events lost at a busy pending slot set sticky overflow.
module ps2_scan_fifo
  import ps2_pkg::*;
#(
  parameter  int CHANNELS = 2,
  parameter  int DEPTH    = 16,
  localparam int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET_N,
  input  logic [8*CHANNELS-1:0] rx_data,
  input  logic [CHANNELS-1:0]   rx_en,
  input  logic                  rd,
  input  logic                  clr_ovf,
  output logic [7:0]            out_code,
  output logic                  out_ext,
  output logic                  out_brk,
  output logic [CW-1:0]         out_chan,
  output logic                  empty,
  output logic                  full,
  output logic [AW:0]           count,
  output logic                  overflow
);

  logic [CHANNELS-1:0] pend_valid;
  logic [CHANNELS-1:0] grant;
  logic [CHANNELS-1:0] drop;
  ps2_evt_t            pend_event [CHANNELS];

  for (genvar i = 0; i < CHANNELS; i++) begin : g_dec
    ps2_prefix_dec #(.CHAN(i)) u_dec (
      .CLOCK_50   (CLOCK_50),
      .RESET_N    (RESET_N),
      .rx_data    (rx_data[8*i +: 8]),
      .rx_en      (rx_en[i]),
      .grant      (grant[i]),
      .pend_valid (pend_valid[i]),
      .pend_event (pend_event[i]),
      .drop       (drop[i])
    );
  end

  logic     wr_en;
  logic     rd_en;
  ps2_evt_t wr_evt;

  // Lowest channel index wins; a read in the same cycle frees the slot of a full FIFO.
  always_comb begin
    grant  = '0;
    wr_en  = 1'b0;
    wr_evt = '0;
    if (!full || rd) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (pend_valid[i] && !wr_en) begin
          grant[i] = 1'b1;
          wr_en    = 1'b1;
          wr_evt   = pend_event[i];
        end
      end
    end
  end

  assign rd_en = rd && !empty;

  ps2_evt_t      mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge CLOCK_50) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_evt;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (|drop) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));

  // Outputs read as zero while empty so stale storage never leaks out after reset or a drain.
  ps2_evt_t head;
  logic     unused_chan_bits;

  assign head             = empty ? '0 : mem[rd_ptr];
  assign out_code         = head.code;
  assign out_ext          = head.ext;
  assign out_brk          = head.brk;
  assign out_chan         = head.chan[CW-1:0];
  assign unused_chan_bits = ^head.chan;

endmodule

// File: tb/tb_ps2_scan_fifo.sv
// Bench for ps2_scan_fifo: directed vector table, hand-built full/overflow/wrap/reset sequences,
// and random traffic, all checked against a queue-based reference model.
module tb_ps2_scan_fifo;

  localparam int CH    = 2;
  localparam int DEPTH = 16;
  localparam int CW    = 1;
  localparam int AW    = 4;

  logic              CLOCK_50;
  logic              RESET_N;
  logic [8*CH-1:0]   rx_data;
  logic [CH-1:0]     rx_en;
  logic              rd;
  logic              clr_ovf;
  logic [7:0]        out_code;
  logic              out_ext;
  logic              out_brk;
  logic [CW-1:0]     out_chan;
  logic              empty;
  logic              full;
  logic [AW:0]       count;
  logic              overflow;

  ps2_scan_fifo #(.CHANNELS(CH), .DEPTH(DEPTH)) dut (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .rx_data  (rx_data),
    .rx_en    (rx_en),
    .rd       (rd),
    .clr_ovf  (clr_ovf),
    .out_code (out_code),
    .out_ext  (out_ext),
    .out_brk  (out_brk),
    .out_chan (out_chan),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .overflow (overflow)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: event queue, per-channel flags and single pending slots.
  typedef struct {
    int code;
    bit ext;
    bit brk;
    int chan;
  } mev_t;

  mev_t m_q[$];
  mev_t m_pe[CH];
  bit   m_ext[CH];
  bit   m_brk[CH];
  bit   m_pv[CH];
  bit   m_ovf;

  function automatic void m_reset();
    m_q.delete();
    for (int i = 0; i < CH; i++) begin
      m_ext[i] = 0;
      m_brk[i] = 0;
      m_pv[i]  = 0;
    end
    m_ovf = 0;
  endfunction

  function automatic void m_step(input logic [8*CH-1:0] data, input logic [CH-1:0] en,
                                 input bit r, input bit c);
    bit pv_pre[CH];
    bit room;
    bit done;
    bit dropped;
    int b;
    dropped = 0;
    done    = 0;
    pv_pre  = m_pv;
    room    = (m_q.size() < DEPTH) || r;
    if (r && m_q.size() > 0) void'(m_q.pop_front());
    if (room) begin
      for (int i = 0; i < CH; i++) begin
        if (pv_pre[i] && !done) begin
          m_q.push_back(m_pe[i]);
          m_pv[i] = 0;
          done    = 1;
        end
      end
    end
    for (int i = 0; i < CH; i++) begin
      if (en[i]) begin
        b = int'(data[8*i +: 8]);
        if (b == 'hE0) m_ext[i] = 1;
        else if (b == 'hF0) m_brk[i] = 1;
        else begin
          if (pv_pre[i]) dropped = 1;
          else begin
            m_pe[i] = '{code: b, ext: m_ext[i], brk: m_brk[i], chan: i};
            m_pv[i] = 1;
          end
          m_ext[i] = 0;
          m_brk[i] = 0;
        end
      end
    end
    if (dropped) m_ovf = 1;
    else if (c) m_ovf = 0;
  endfunction

  task automatic compare_model();
    chk("m_count", int'(count), m_q.size());
    chk("m_empty", int'(empty), int'(m_q.size() == 0));
    chk("m_full", int'(full), int'(m_q.size() == DEPTH));
    chk("m_ovf", int'(overflow), int'(m_ovf));
    if (m_q.size() > 0) begin
      chk("m_code", int'(out_code), m_q[0].code);
      chk("m_ext", int'(out_ext), int'(m_q[0].ext));
      chk("m_brk", int'(out_brk), int'(m_q[0].brk));
      chk("m_chan", int'(out_chan), m_q[0].chan);
    end
  endtask

  task automatic step(input logic [8*CH-1:0] data, input logic [CH-1:0] en,
                      input bit r, input bit c);
    rx_data = data;
    rx_en   = en;
    rd      = r;
    clr_ovf = c;
    @(posedge CLOCK_50);
    m_step(data, en, r, c);
    #1;
    compare_model();
  endtask

  task automatic idle();
    step('0, '0, 0, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_code"}, int'(out_code), 0);
    chk({tag, "_ext"}, int'(out_ext), 0);
    chk({tag, "_brk"}, int'(out_brk), 0);
    chk({tag, "_chan"}, int'(out_chan), 0);
    chk({tag, "_empty"}, int'(empty), 1);
    chk({tag, "_full"}, int'(full), 0);
    chk({tag, "_count"}, int'(count), 0);
    chk({tag, "_ovf"}, int'(overflow), 0);
  endtask

  typedef struct {
    logic [15:0] data;
    logic [1:0]  en;
    bit          r;
    bit          c;
    int          e_cnt;
    int          e_code;
    bit          e_ext;
    bit          e_brk;
    int          e_chan;
    bit          e_ovf;
  } vec_t;

  vec_t tbl[15];
  int   drain_exp[16];

  initial begin
    tbl[0]  = '{16'h001C, 2'b01, 0, 0, 0, 'h00, 0, 0, 0, 0};
    tbl[1]  = '{16'h0000, 2'b00, 0, 0, 1, 'h1C, 0, 0, 0, 0};
    tbl[2]  = '{16'h0000, 2'b00, 1, 0, 0, 'h00, 0, 0, 0, 0};
    tbl[3]  = '{16'hE000, 2'b10, 0, 0, 0, 'h00, 0, 0, 0, 0};
    tbl[4]  = '{16'hF000, 2'b10, 0, 0, 0, 'h00, 0, 0, 0, 0};
    tbl[5]  = '{16'h7500, 2'b10, 0, 0, 0, 'h00, 0, 0, 0, 0};
    tbl[6]  = '{16'h0000, 2'b00, 0, 0, 1, 'h75, 1, 1, 1, 0};
    tbl[7]  = '{16'h7500, 2'b10, 1, 0, 0, 'h00, 0, 0, 0, 0};
    tbl[8]  = '{16'h0000, 2'b00, 0, 0, 1, 'h75, 0, 0, 1, 0};
    tbl[9]  = '{16'h0000, 2'b00, 1, 0, 0, 'h00, 0, 0, 0, 0};
    tbl[10] = '{16'h1E16, 2'b11, 0, 0, 0, 'h00, 0, 0, 0, 0};
    tbl[11] = '{16'h0000, 2'b00, 0, 0, 1, 'h16, 0, 0, 0, 0};
    tbl[12] = '{16'h0000, 2'b00, 0, 0, 2, 'h16, 0, 0, 0, 0};
    tbl[13] = '{16'h0000, 2'b00, 1, 0, 1, 'h1E, 0, 0, 1, 0};
    tbl[14] = '{16'h0000, 2'b00, 1, 0, 0, 'h00, 0, 0, 0, 0};

    RESET_N = 1'b0;
    rx_data = '0;
    rx_en   = '0;
    rd      = 1'b0;
    clr_ovf = 1'b0;
    m_reset();
    repeat (3) @(posedge CLOCK_50);
    #1;
    chk_reset_vals("por");
    @(negedge CLOCK_50);
    RESET_N = 1'b1;

    // Directed vectors
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].data, tbl[i].en, tbl[i].r, tbl[i].c);
      chk($sformatf("v%0d_count", i), int'(count), tbl[i].e_cnt);
      chk($sformatf("v%0d_empty", i), int'(empty), int'(tbl[i].e_cnt == 0));
      chk($sformatf("v%0d_ovf", i), int'(overflow), int'(tbl[i].e_ovf));
      if (tbl[i].e_cnt != 0) begin
        chk($sformatf("v%0d_code", i), int'(out_code), tbl[i].e_code);
        chk($sformatf("v%0d_ext", i), int'(out_ext), int'(tbl[i].e_ext));
        chk($sformatf("v%0d_brk", i), int'(out_brk), int'(tbl[i].e_brk));
        chk($sformatf("v%0d_chan", i), int'(out_chan), tbl[i].e_chan);
      end
    end

    // Fill to DEPTH (pointers start mid-array, so this wraps)
    for (int i = 0; i < DEPTH; i++) begin
      step(16'(8'h10 + i), 2'b01, 0, 0);
      idle();
    end
    chk("fill_full", int'(full), 1);
    chk("fill_count", int'(count), DEPTH);
    step(16'h0040, 2'b01, 0, 0);
    idle();
    chk("held_count", int'(count), DEPTH);
    chk("held_ovf", int'(overflow), 0);
    step(16'h0041, 2'b01, 0, 0);
    chk("drop_ovf", int'(overflow), 1);
    chk("drop_count", int'(count), DEPTH);
    step('0, '0, 1, 0);
    chk("rdfull_count", int'(count), DEPTH);
    chk("rdfull_head", int'(out_code), 'h11);
    step('0, '0, 0, 1);
    chk("clr_ovf", int'(overflow), 0);
    step(16'h5000, 2'b10, 0, 0);
    step('0, '0, 1, 0);
    chk("rdpend_count", int'(count), DEPTH);
    chk("rdpend_head", int'(out_code), 'h12);
    for (int k = 0; k < 14; k++) drain_exp[k] = 'h12 + k;
    drain_exp[14] = 'h40;
    drain_exp[15] = 'h50;
    for (int k = 0; k < DEPTH; k++) begin
      chk($sformatf("drain%0d", k), int'(out_code), drain_exp[k]);
      step('0, '0, 1, 0);
    end
    chk("drain_empty", int'(empty), 1);
    step('0, '0, 1, 0);
    chk("rd_empty_noop", int'(count), 0);

    // Reset with queued entries, a pending prefix and overflow set
    step(16'h0021, 2'b01, 0, 0);
    step(16'h3000, 2'b10, 0, 0);
    step(16'h3100, 2'b10, 0, 0);
    step(16'h0022, 2'b01, 0, 0);
    idle();
    chk("prerst_count", int'(count), 3);
    chk("prerst_ovf", int'(overflow), 1);
    step(16'h00E0, 2'b01, 0, 0);
    #2;
    RESET_N = 1'b0;
    #1;
    chk_reset_vals("mid");
    m_reset();
    @(negedge CLOCK_50);
    RESET_N = 1'b1;
    step(16'h001C, 2'b01, 0, 0);
    idle();
    chk("postrst_code", int'(out_code), 'h1C);
    chk("postrst_ext", int'(out_ext), 0);
    chk("postrst_count", int'(count), 1);

    // Random traffic with alternating read pressure
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [8*CH-1:0] d;
      logic [CH-1:0]   e;
      bit              r;
      bit              c;
      for (int i = 0; i < CH; i++) begin
        int sel;
        sel = int'($urandom_range(0, 5));
        d[8*i +: 8] = (sel == 0) ? 8'hE0 : (sel == 1) ? 8'hF0 : 8'($urandom);
        e[i] = ($urandom_range(0, 3) == 0);
      end
      r = ((cyc / 300) % 2 == 0) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 0);
      c = ($urandom_range(0, 19) == 0);
      step(d, e, r, c);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ps2_scan_fifo.md
# ps2_scan_fifo

Multi-channel PS/2 scancode collector that replaces the single latched byte register behind each `ps2_keyboard` receiver. It takes each channel's received-byte strobe and folds the E0 (extended) and F0 (break) prefixes into flags. Completed scancode events are arbitrated into one show-ahead FIFO for the consumer (CPU port or HEX debug display). Overflow is reported with a sticky flag.

## Interface
- `CHANNELS`, 2: number of PS/2 receivers (1..4).
- `DEPTH`, 16: FIFO entries, power of two, ≥2.
- `CW`, derived, max(1, clog2(CHANNELS)): channel tag width.
- `AW`, derived, clog2(DEPTH): FIFO pointer width.

- `CLOCK_50` in 1: sole clock; all logic on posedge.
- `RESET_N` in 1: reset, asynchronous, active-low.
- `rx_data` in 8*CHANNELS: channel i byte in bits [8i+7:8i].
- `rx_en` in CHANNELS: 1-cycle strobe; byte i is valid when bit i = 1.
- `rd` in 1: pop head entry; ignored when `empty`.
- `clr_ovf` in 1: clears `overflow`.
- `out_code` out 8: head scancode.
- `out_ext` out 1: head event had an E0 prefix.
- `out_brk` out 1: head event had an F0 prefix (key release).
- `out_chan` out CW: source channel of the head event.
- `empty` out 1: FIFO holds no entries.
- `full` out 1: FIFO holds DEPTH entries.
- `count` out AW+1: number of entries, 0..DEPTH.
- `overflow` out 1: sticky; set when an event is lost.

## Operation
- Prefix decoder per channel holds flags `ext` and `brk`.
  - Byte E0 sets `ext`. Byte F0 sets `brk`. Repeated prefixes are idempotent. Neither produces an event.
  - Any other byte, including AA, FA, FE and E1, produces an event {chan, ext, brk, code} and clears both flags on the same edge.
- Pending register per channel (1 entry) captures the event.
- Arbiter uses fixed priority, lowest channel index first. It grants one pending entry per cycle when `!full || rd`. A granted entry is written and its pending register cleared. Losing entries hold.
- Event arriving while that channel's pending is still valid: the new event is dropped, `overflow` is set, and the held entry is kept.
- FIFO is show-ahead: `out_*` always reflect the head entry. `rd` with `!empty` advances the head on the next edge.
- Write and read in the same cycle: `count` is unchanged. This is legal when full, because the write is gated by `!full || rd`.
- `rd` while `empty` is a no-op, with no pointer movement.
- Pointers wrap modulo DEPTH. `full` and `empty` derive from `count`.
- `clr_ovf` in the same cycle as a new overflow: set wins.

## Timing
- Reset values: `out_code`=0, `out_ext`=0, `out_brk`=0, `out_chan`=0, `empty`=1, `full`=0, `count`=0, `overflow`=0. Decoder flags and pending-valid bits are cleared.
- Reset asserted mid-prefix or with entries queued discards everything. The first byte after release decodes with clear flags.
- Latency:
  - Edge k samples a non-prefix `rx_en`; the pending entry is valid after edge k.
  - Write happens at edge k+1 if granted.
  - `empty`=0 and `out_*` are valid after edge k+1. Minimum is 2 cycles.
- A simultaneous strobe on all channels drains in CHANNELS cycles when there is FIFO room.
- `overflow` rises on the edge that drops the event.

## Structure
- Package `ps2_pkg`: constants `PS2_PFX_EXT`=8'hE0 and `PS2_PFX_BRK`=8'hF0, plus the event record layout {chan, ext, brk, code[7:0]}. Shared with `ps2_keyboard` users.
- Sub-module `ps2_prefix_dec`: one instance per channel, containing the flags and pending register. Its outputs are `pend_valid` and `pend_event`, and it takes a `grant` input.
- FIFO storage is a register array inside `ps2_scan_fifo`.

## Test plan
- Ch0 receives 1C: after 2 cycles `empty`=0 and {code 1C, ext 0, brk 0, chan 0}. `rd` → `empty`=1.
- Ch1 receives E0, F0, 75: one entry {75, ext 1, brk 1, chan 1}. Ch1 then receives 75: entry {75, 0, 0, 1}, showing the flags were cleared.
- Ch0 and ch1 strobe 16 and 1E in the same cycle: FIFO order is ch0/16 then ch1/1E, and `count`=2.
- DEPTH events with no reads: `full`=1 and `count`=DEPTH. Next event stays pending. A second event on the same channel sets `overflow`=1. One `rd` lets the pending entry enter. `clr_ovf` clears the flag.
- `rd` while full and a pending entry exists in the same cycle: `count` stays DEPTH, and the head advances correctly across pointer wrap.
- Reset asserted after E0 with 3 entries queued: all outputs return to their reset values. Next byte 1C yields ext 0.
